// File: rtl/button_evt_pkg.sv
// Shared definitions for button_event_queue: register offsets, field positions
// and the event mask layout used by both the FIFO entries and the DATA register.
package button_evt_pkg;

  // Register index as decoded from HADDR[3:2]
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_THRESH = 2'd3;

  localparam int DATA_MASK_LSB  = 0;
  localparam int DATA_TS_LSB    = 8;
  localparam int DATA_VALID_BIT = 31;

  localparam int STATUS_EMPTY_BIT = 8;
  localparam int STATUS_FULL_BIT  = 9;
  localparam int STATUS_OVF_BIT   = 10;

  localparam int CTRL_IRQEN_BIT  = 0;
  localparam int CTRL_FLUSH_BIT  = 1;
  localparam int CTRL_CLROVF_BIT = 2;

  localparam int THRESH_W = 6;

  typedef struct packed {
    logic setting;
    logic trip;
    logic mode;
    logic day_night;
  } evt_mask_t;

endpackage

// File: rtl/evt_fifo_core.sv
// Synchronous FIFO with count, flush and an optional overwrite-oldest policy
// selected by the EVT_FIFO_OVERWRITE_EN macro (default: drop newest when full).
module evt_fifo_core #(
  parameter int DEPTH = 8,
  parameter int W     = 20,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_next,
  output logic          empty,
  output logic          full,
  output logic          overflow_evt
);

`ifdef EVT_FIFO_OVERWRITE_EN
  localparam bit OVERWRITE = 1'b1;
`else
  localparam bit OVERWRITE = 1'b0;
`endif

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop_ok, do_push, adv_rd;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign rdata = mem[rd_ptr];

  // push/pop are single-cycle requests; a pop on an empty FIFO is ignored and
  // flush overrides both.
  always_comb begin
    pop_ok       = pop && !empty && !flush;
    overflow_evt = push && !flush && full && !pop_ok;
    do_push      = push && !flush && (!full || pop_ok || OVERWRITE);
    adv_rd       = pop_ok || (OVERWRITE && overflow_evt);
    count_next   = count;
    if (flush)
      count_next = '0;
    else if (do_push && !adv_rd)
      count_next = count + CW'(1);
    else if (adv_rd && !do_push)
      count_next = count - CW'(1);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (adv_rd)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
    end
  end

  always_ff @(posedge HCLK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/button_event_queue.sv
// AHB-Lite slave buffering timestamped button events with a level IRQ.
// Build option: EVT_FIFO_OVERWRITE_EN makes a full FIFO overwrite its oldest entry.
module button_event_queue
  import button_evt_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int TS_WIDTH = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic        HSEL,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic        Evt_DayNight,
  input  logic        Evt_Mode,
  input  logic        Evt_Trip,
  input  logic        Evt_Setting,
  input  logic        Tick,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        IRQ
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = TS_WIDTH + 4;

  evt_mask_t             evt_mask;
  logic                  evt_push;
  logic [TS_WIDTH-1:0]   ts;
  logic                  ahb_valid, ahb_write;
  logic [1:0]            ahb_addr;
  logic                  dp_read, dp_wr, ctrl_wr, thresh_wr, flush, fifo_pop;
  logic                  irq_en, overflow;
  logic [THRESH_W-1:0]   thresh, thresh_eff;
  logic [EW-1:0]         fifo_rdata;
  logic [CW-1:0]         count, count_next;
  logic                  empty, full, overflow_evt;
  logic                  unused_ok;

  assign evt_mask  = '{setting: Evt_Setting, trip: Evt_Trip, mode: Evt_Mode, day_night: Evt_DayNight};
  assign evt_push  = |evt_mask;
  assign HREADYOUT = 1'b1;
  assign unused_ok = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA[31:6]};

  always_ff @(posedge HCLK) begin
    if (HRESET)    ts <= '0;
    else if (Tick) ts <= ts + TS_WIDTH'(1);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ahb_valid <= 1'b0;
      ahb_write <= 1'b0;
      ahb_addr  <= 2'd0;
    end else if (HREADY) begin
      ahb_valid <= HSEL && (HTRANS != 2'b00);
      ahb_write <= HWRITE;
      ahb_addr  <= HADDR[3:2];
    end
  end

  assign dp_read   = ahb_valid && !ahb_write;
  assign dp_wr     = ahb_valid && ahb_write;
  assign ctrl_wr   = dp_wr && (ahb_addr == REG_CTRL);
  assign thresh_wr = dp_wr && (ahb_addr == REG_THRESH);
  assign flush     = ctrl_wr && HWDATA[CTRL_FLUSH_BIT];
  assign fifo_pop  = dp_read && (ahb_addr == REG_DATA);

  evt_fifo_core #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .push         (evt_push),
    .pop          (fifo_pop),
    .flush        (flush),
    .wdata        ({ts, evt_mask}),
    .rdata        (fifo_rdata),
    .count        (count),
    .count_next   (count_next),
    .empty        (empty),
    .full         (full),
    .overflow_evt (overflow_evt)
  );

  assign thresh_eff = (thresh == '0) ? THRESH_W'(1) : thresh;

  // IRQ follows the count being committed this edge, so it trails a push/pop
  // by one cycle, while IrqEn/THRESH are taken from their current register.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      irq_en   <= 1'b0;
      thresh   <= '0;
      overflow <= 1'b0;
      IRQ      <= 1'b0;
    end else begin
      if (ctrl_wr)   irq_en <= HWDATA[CTRL_IRQEN_BIT];
      if (thresh_wr) thresh <= HWDATA[THRESH_W-1:0];
      if (overflow_evt)
        overflow <= 1'b1;
      else if (ctrl_wr && HWDATA[CTRL_CLROVF_BIT])
        overflow <= 1'b0;
      IRQ <= irq_en && (THRESH_W'(count_next) >= thresh_eff);
    end
  end

  always_comb begin
    HRDATA = '0;
    if (dp_read) begin
      case (ahb_addr)
        REG_DATA: begin
          if (!empty) begin
            HRDATA = (32'(fifo_rdata[EW-1:4]) << DATA_TS_LSB) |
                     (32'(fifo_rdata[3:0]) << DATA_MASK_LSB);
            HRDATA[DATA_VALID_BIT] = 1'b1;
          end
        end
        REG_STATUS: begin
          HRDATA[5:0]              = 6'(count);
          HRDATA[STATUS_EMPTY_BIT] = empty;
          HRDATA[STATUS_FULL_BIT]  = full;
          HRDATA[STATUS_OVF_BIT]   = overflow;
        end
        REG_CTRL:   HRDATA[CTRL_IRQEN_BIT] = irq_en;
        default:    HRDATA[THRESH_W-1:0]   = thresh;
      endcase
    end
  end

endmodule
